// File: rtl/connect4_pkg.sv
// Shared constants, codes and helpers for the Connect-4 move engine.
package connect4_pkg;

  localparam int ROWS    = 6;
  localparam int COLS    = 7;
  localparam int WIN_LEN = 4;
  localparam int CELLS   = ROWS * COLS;

  localparam int ROW_W   = $clog2(ROWS);
  localparam int COL_W   = $clog2(COLS);
  localparam int CNT_W   = $clog2(CELLS + 1);
  localparam int CELL_W  = $clog2(CELLS);
  localparam int RUN_W   = $clog2(WIN_LEN + 1);

  // Cell codes; a player's piece code doubles as that player's win status code
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam logic [1:0] STAT_NEXT  = 2'b00;
  localparam logic [1:0] STAT_TIE   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_PLACE, S_CHECK, S_REPORT, S_DONE
  } state_e;

  // Board flattened row-major: cell (r,c) lives at r*COLS+c
  typedef logic [CELLS-1:0][1:0] board_t;

  // Direction step table: 0 horizontal, 1 vertical, 2 diag (+1,+1), 3 diag (+1,-1)
  function automatic logic signed [1:0] dir_dr(input logic [1:0] d);
    return (d == 2'd0) ? 2'sb00 : 2'sb01;
  endfunction

  function automatic logic signed [1:0] dir_dc(input logic [1:0] d);
    case (d)
      2'd0:    return 2'sb01;
      2'd1:    return 2'sb00;
      2'd2:    return 2'sb01;
      default: return 2'sb11;
    endcase
  endfunction

  function automatic logic [CELL_W-1:0] cell_idx(input logic [ROW_W-1:0] r,
                                                 input logic [COL_W-1:0] c);
    return CELL_W'(r) * CELL_W'(COLS) + CELL_W'(c);
  endfunction

endpackage

// File: rtl/connect4_line_counter.sv
// Combinational run-length counter through one cell along one direction.
module connect4_line_counter
  import connect4_pkg::*;
(
  input  board_t             board,
  input  logic [ROW_W-1:0]   row,
  input  logic [COL_W-1:0]   col,
  input  logic signed [1:0]  dr,
  input  logic signed [1:0]  dc,
  input  logic [1:0]         piece,
  output logic [RUN_W-1:0]   run
);

  int               r, c, cnt, sg;
  logic             go;
  logic [CELL_W-1:0] idx;

  // Walk up to WIN_LEN-1 cells each way, stopping at the edge or a foreign cell
  always_comb begin
    r   = 0;
    c   = 0;
    sg  = 1;
    go  = 1'b1;
    idx = '0;
    cnt = 1;
    for (int s = 0; s < 2; s++) begin
      sg = (s == 0) ? 1 : -1;
      go = 1'b1;
      for (int k = 1; k < WIN_LEN; k++) begin
        r = int'(row) + sg * k * int'(dr);
        c = int'(col) + sg * k * int'(dc);
        if (go && r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
          idx = CELL_W'(r * COLS + c);
          if (board[idx] == piece) cnt = cnt + 1;
          else                     go  = 1'b0;
        end else begin
          go = 1'b0;
        end
      end
    end
    run = (cnt >= WIN_LEN) ? RUN_W'(WIN_LEN) : RUN_W'(cnt);
  end

endmodule

// File: rtl/connect4_move_engine.sv
// Connect-4 move engine: accepts drops, holds the board, checks for a win
// one direction per cycle and reports status/turn to the game-control FSM.
module connect4_move_engine
  import connect4_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] game_state,
  input  logic       move_valid,
  input  logic [2:0] move_col,
  output logic       move_ready,
  output logic       move_err,
  output logic [1:0] in_game_status,
  output logic       player_turn,
  output logic       status_valid,
  input  logic [2:0] rd_row,
  input  logic [2:0] rd_col,
  output logic [1:0] rd_cell
);

  state_e                     state_q, state_d;
  board_t                     board_q, board_d;
  logic [COLS-1:0][ROW_W-1:0] height_q, height_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [ROW_W-1:0]           row_q, row_d;
  logic [COL_W-1:0]           col_q, col_d;
  logic [1:0]                 piece_q, piece_d;
  logic [1:0]                 dir_q, dir_d;
  logic [1:0]                 status_q, status_d;
  logic                       turn_q, turn_d;
  logic                       err_q, err_d;
  logic [1:0]                 rd_cell_q, rd_cell_d;
  logic [RUN_W-1:0]           run;

  connect4_line_counter u_line (
    .board (board_q),
    .row   (row_q),
    .col   (col_q),
    .dr    (dir_dr(dir_q)),
    .dc    (dir_dc(dir_q)),
    .piece (piece_q),
    .run   (run)
  );

  assign move_ready     = (state_q == S_IDLE) && (game_state == 2'b01 || game_state == 2'b10);
  assign move_err       = err_q;
  assign in_game_status = status_q;
  assign player_turn    = turn_q;
  assign status_valid   = (state_q == S_REPORT);
  assign rd_cell        = rd_cell_q;

  // Next-state, board update and status decision
  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    height_d  = height_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    piece_d   = piece_q;
    dir_d     = dir_q;
    status_d  = status_q;
    turn_d    = turn_q;
    err_d     = 1'b0;
    rd_cell_d = (rd_row < 3'(ROWS) && rd_col < 3'(COLS)) ? board_q[cell_idx(rd_row, rd_col)]
                                                         : CELL_EMPTY;
    case (state_q)
      S_IDLE: begin
        if (move_valid && move_ready) begin
          if (move_col >= 3'(COLS)) begin
            err_d = 1'b1;
          end else if (height_q[move_col] == ROW_W'(ROWS)) begin
            err_d = 1'b1;
          end else begin
            col_d   = move_col;
            row_d   = height_q[move_col];
            piece_d = turn_q ? CELL_P2 : CELL_P1;
            state_d = S_PLACE;
          end
        end
      end
      S_PLACE: begin
        board_d[cell_idx(row_q, col_q)] = piece_q;
        height_d[col_q] = height_q[col_q] + ROW_W'(1);
        cnt_d           = cnt_q + CNT_W'(1);
        dir_d           = 2'd0;
        state_d         = S_CHECK;
      end
      S_CHECK: begin
        // Status is registered on the way into REPORT so it is visible there
        if (run >= RUN_W'(WIN_LEN)) begin
          status_d = piece_q;
          state_d  = S_REPORT;
        end else if (dir_q == 2'd3) begin
          if (cnt_q == CNT_W'(CELLS)) begin
            status_d = STAT_TIE;
          end else begin
            status_d = STAT_NEXT;
            turn_d   = ~turn_q;
          end
          state_d = S_REPORT;
        end else begin
          dir_d = dir_q + 2'd1;
        end
      end
      S_REPORT: state_d = (status_q == STAT_NEXT) ? S_IDLE : S_DONE;
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      board_q   <= '0;
      height_q  <= '0;
      cnt_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      piece_q   <= CELL_EMPTY;
      dir_q     <= '0;
      status_q  <= STAT_NEXT;
      turn_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_cell_q <= CELL_EMPTY;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      height_q  <= height_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      piece_q   <= piece_d;
      dir_q     <= dir_d;
      status_q  <= status_d;
      turn_q    <= turn_d;
      err_q     <= err_d;
      rd_cell_q <= rd_cell_d;
    end
  end

endmodule
